regfile_rw: RTL

- 32 x 32-bit RV32I integer register file; the producer side of the operand-latch interface.
- Supplies read_data_1/read_data_2 combinationally, for capture by the operand latch on the next clk edge.
- Accepts the core write-back port and a debug (SPI-bridge) access port with a req/ack handshake.
- x0 is hardwired to zero.

---
 rtl/regfile_rw.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/regfile_rw.sv
// ---------------------------------------------------------------------------
// regfile_rw
//   RV32I integer register file (x0 hardwired to zero). It has two
//   combinational read ports for the operand latch, one core write-back port
//   and a debug access port with a req/ack handshake. The debug port is
//   driven by the SPI bridge.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   read_reg_1/2             rs1/rs2 addresses
//   read_data_1/2            rs1/rs2 data (combinational)
//   reg_write, write_reg,    core write-back port
//   write_data
//   dbg_req, dbg_we,         debug request. Held until dbg_ack. Direction,
//   dbg_addr, dbg_wdata      address and data are stable while dbg_req is high.
//   dbg_rdata                debug read data (registered, held between reads)
//   dbg_ack                  single-cycle completion pulse
//   dbg_busy                 high while a debug transaction is in progress
// ---------------------------------------------------------------------------
module regfile_rw #(
  parameter int NREGS  = 32,
  parameter int XLEN   = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      read_reg_1,
  input  logic [4:0]      read_reg_2,
  output logic [XLEN-1:0] read_data_1,
  output logic [XLEN-1:0] read_data_2,
  input  logic            reg_write,
  input  logic [4:0]      write_reg,
  input  logic [XLEN-1:0] write_data,
  input  logic            dbg_req,
  input  logic            dbg_we,
  input  logic [4:0]      dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  output logic [XLEN-1:0] dbg_rdata,
  output logic            dbg_ack,
  output logic            dbg_busy
);

  typedef enum logic [1:0] {
    IDLE,
    SERVICE,
    ACK
  } state_t;

  state_t          state;
  logic [XLEN-1:0] mem [NREGS];
  logic            core_wr;
  logic [XLEN-1:0] dbg_view;

  // A core write to x0 is a no-op everywhere: it causes no update, no bypass
  // and no debug stall.
  assign core_wr = reg_write && (write_reg != 5'd0);

  // NOTE: every branch of a combinational block assigns its outputs, and a
  // default comes first. An output that is left unassigned on some path
  // infers a latch.
  always_comb begin
    read_data_1 = '0;
    if (read_reg_1 != 5'd0) begin
      if (BYPASS && core_wr && (write_reg == read_reg_1))
        read_data_1 = write_data;
      else
        read_data_1 = mem[read_reg_1];
    end
  end

  always_comb begin
    read_data_2 = '0;
    if (read_reg_2 != 5'd0) begin
      if (BYPASS && core_wr && (write_reg == read_reg_2))
        read_data_2 = write_data;
      else
        read_data_2 = mem[read_reg_2];
    end
  end

  // This is the value a debug read captures. A core write that commits on the
  // same edge is visible only when bypass is enabled.
  always_comb begin
    dbg_view = '0;
    if (dbg_addr != 5'd0) begin
      if (BYPASS && core_wr && (write_reg == dbg_addr))
        dbg_view = write_data;
      else
        dbg_view = mem[dbg_addr];
    end
  end

  // The storage array and the debug FSM share one process, so that both write
  // sources of mem are arbitrated in a single place.
  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together at the edge, whatever order the statements are in.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the architectural state must read zero after reset, so the
      // array is cleared explicitly. This rules out mapping it to a plain
      // RAM macro that has no reset.
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      state     <= IDLE;
      dbg_rdata <= '0;
      dbg_ack   <= 1'b0;
      dbg_busy  <= 1'b0;
    end else begin
      if (core_wr) mem[write_reg] <= write_data;

      unique case (state)
        IDLE: begin
          dbg_ack <= 1'b0;
          if (dbg_req) begin
            state    <= SERVICE;
            dbg_busy <= 1'b1;
          end
        end

        SERVICE: begin
          if (!dbg_we) begin
            dbg_rdata <= dbg_view;
            dbg_ack   <= 1'b1;
            state     <= ACK;
          end else if (!core_wr) begin
            // The core has priority on the write port. A debug write only
            // commits in a cycle with no core write at all, so there is never
            // a second write to arbitrate.
            if (dbg_addr != 5'd0) mem[dbg_addr] <= dbg_wdata;
            dbg_ack <= 1'b1;
            state   <= ACK;
          end
        end

        ACK: begin
          dbg_ack  <= 1'b0;
          dbg_busy <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          dbg_ack  <= 1'b0;
          dbg_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
